// File: rtl/ram_port_responder_if.sv
// Core-to-responder RAM port bundle: request fields driven by the core,
// registered load data and unmapped-access pulse returned by the responder.
interface ram_port_responder_if;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;
    logic        bus_error;

    modport master (
        output ram_en, ram_write_en, ram_addr, ram_write_data,
        input  ram_read_data, bus_error
    );

    modport slave (
        input  ram_en, ram_write_en, ram_addr, ram_write_data,
        output ram_read_data, bus_error
    );
endinterface

// File: rtl/ram_port_responder.sv
// Data-memory responder: byte-writable RAM plus LED/switch/timer MMIO block.
// Optional compare timer is built only when RAM_PORT_TIMER_EN is defined.
module ram_port_responder #(
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int LED_WIDTH      = 16,
    parameter int SW_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_port_responder_if.slave  bus,
    output logic [LED_WIDTH-1:0] led,
    input  logic [SW_WIDTH-1:0]  sw,
    output logic                 timer_irq
);

    localparam int DEPTH = 1 << RAM_ADDR_WIDTH;

    localparam logic [5:0] SEL_LED    = 6'd0;
    localparam logic [5:0] SEL_SW     = 6'd1;
    localparam logic [5:0] SEL_TCOUNT = 6'd2;
    localparam logic [5:0] SEL_TCMP   = 6'd3;
    localparam logic [5:0] SEL_TSTAT  = 6'd4;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0]               mem [DEPTH];
    logic [RAM_ADDR_WIDTH-1:0] word_idx;
    logic [5:0]                reg_sel;
    logic                      hit_ram;
    logic                      hit_mmio;
    logic                      is_write;
    logic                      wr_mmio;
    logic [31:0]               mmio_rdata;
    logic [SW_WIDTH-1:0]       sw_meta;
    logic [SW_WIDTH-1:0]       sw_sync;
    logic                      unused_addr_bits;

    assign unused_addr_bits = ^bus.ram_addr[1:0];

    always_comb begin
        word_idx = bus.ram_addr[RAM_ADDR_WIDTH+1:2];
        reg_sel  = bus.ram_addr[7:2];
        is_write = |bus.ram_write_en;
        hit_ram  = bus.ram_en && (bus.ram_addr[31:28] == 4'h0) &&
                   (bus.ram_addr[27:RAM_ADDR_WIDTH+2] == '0);
        hit_mmio = bus.ram_en && (bus.ram_addr[31:8] == 24'h100000);
        wr_mmio  = hit_mmio && is_write;
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (hit_ram && is_write) begin
            mem[word_idx] <= merge_lanes(mem[word_idx], bus.ram_write_data, bus.ram_write_en);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led <= '0;
        end else if (wr_mmio && reg_sel == SEL_LED) begin
            led <= LED_WIDTH'(merge_lanes(32'(led), bus.ram_write_data, bus.ram_write_en));
        end
    end

`ifdef RAM_PORT_TIMER_EN
    logic [31:0] tcount;
    logic [31:0] tcmp;
    logic        tmatch;
    logic        match_set;
    logic        match_clr;

    assign match_set = (tcount == tcmp) && (tcmp != 32'd0);
    assign match_clr = wr_mmio && (reg_sel == SEL_TSTAT) &&
                       bus.ram_write_en[0] && bus.ram_write_data[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcount <= '0;
            tcmp   <= '0;
            tmatch <= 1'b0;
        end else begin
            // A count write overrides only the written lanes of the increment.
            if (wr_mmio && reg_sel == SEL_TCOUNT) begin
                tcount <= merge_lanes(tcount + 32'd1, bus.ram_write_data, bus.ram_write_en);
            end else begin
                tcount <= tcount + 32'd1;
            end
            if (wr_mmio && reg_sel == SEL_TCMP) begin
                tcmp <= merge_lanes(tcmp, bus.ram_write_data, bus.ram_write_en);
            end
            tmatch <= match_set || (tmatch && !match_clr);
        end
    end

    assign timer_irq = tmatch;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        mmio_rdata = 32'd0;
        case (reg_sel)
            SEL_LED:    mmio_rdata = 32'(led);
            SEL_SW:     mmio_rdata = 32'(sw_sync);
`ifdef RAM_PORT_TIMER_EN
            SEL_TCOUNT: mmio_rdata = tcount;
            SEL_TCMP:   mmio_rdata = tcmp;
            SEL_TSTAT:  mmio_rdata = {31'd0, tmatch};
`endif
            default:    mmio_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ram_read_data <= '0;
            bus.bus_error     <= 1'b0;
        end else begin
            bus.bus_error <= bus.ram_en && !hit_ram && !hit_mmio;
            if (bus.ram_en && !is_write) begin
                if (hit_ram) begin
                    bus.ram_read_data <= mem[word_idx];
                end else if (hit_mmio) begin
                    bus.ram_read_data <= mmio_rdata;
                end else begin
                    bus.ram_read_data <= 32'd0;
                end
            end
        end
    end

endmodule
